mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between two requesters:
  - the multicycle core's memory interface (requester C, driven by MemRead/MemWrite/IorD);
  - the debug/DMA loader (requester D).
- Arbitrates round-robin, registers the winning request, and holds it stable on the memory side until the variable-latency memory acknowledges.
- Returns the read data with a one-cycle done pulse.
- A watchdog terminates any transaction whose ack never arrives.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 16, maximum BUSY cycles before forced completion with error; legal range 2..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- c_req  in  1  core request; held high until c_done.
- c_we  in  1  core write enable (1 = store, 0 = fetch or load).
- c_addr  in  ADDR_W  core address.
- c_wdata  in  DATA_W  core store data.
- c_done  out  1  one-cycle completion pulse to the core.
- c_rdata  out  DATA_W  read data; valid while c_done=1.
- c_err  out  1  timeout flag; valid while c_done=1.
- d_req, d_we, d_addr, d_wdata  in  DMA request signals; same rules as the core.
- d_done, d_rdata, d_err  out  DMA response signals; same rules as the core.
- mem_req  out  1  memory request; held high until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  memory completion, sampled only while mem_req=1.
- mem_rdata  in  DATA_W  read data; valid with mem_ack.
- busy  out  1  arbiter is not in IDLE.
- owner  out  1  current or last grant (0 = core, 1 = DMA).

Behaviour:
- Reset (synchronous, dominates everything):
  - state = IDLE;
  - all outputs = 0, including owner = 0;
  - internal last_grant = 1, so the core wins the first tie;
  - watchdog counter = 0.
- The FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - With no request, stay in IDLE.
  - With exactly one req, grant that requester.
  - With both requesting, grant the requester that is not last_grant.
  - On a grant, latch we/addr/wdata into the mem_* registers, set owner and last_grant, clear the counter, and go to BUSY.
- BUSY:
  - mem_req = 1; mem_we, mem_addr and mem_wdata stay stable throughout.
  - On mem_ack=1: capture mem_rdata into the owner's rdata, err = 0, go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 and no ack is present, go to DONE with rdata = 0 and err = 1.
  - If the ack and the timeout land in the same cycle, the ack wins (err = 0).
  - Requester inputs are ignored in BUSY. Dropping req mid-transaction does not abort it, and the done pulse is still issued.
- DONE:
  - The owner's done = 1 for exactly one cycle; mem_req = 0; no arbitration takes place; next state is IDLE.
  - rdata and err hold their values until that requester's next done.
  - The non-owner's done is always 0.
- Latency:
  - Grant is registered in the cycle req is seen in IDLE (edge 0); mem_req is high from cycle 1.
  - An ack in BUSY cycle k (first BUSY cycle = 1) gives done in cycle k+1.
  - Minimum turnaround is 3 cycles (IDLE, BUSY, DONE).
  - A requester that still holds req in the IDLE cycle after done starts a new transaction. The core FSM drops its request on done.
- Fairness: with both requesters continuously active, grants alternate C, D, C, D.
- The arbiter never issues mem_req for two transactions without an intervening DONE state.

Decomposition:
- Shared package mem_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, BUSY, DONE};
  - localparams OWNER_CORE = 0 and OWNER_DMA = 1.
- One sub-module: arb_watchdog, a counter with clear/enable inputs and an expire output at TIMEOUT-1.
- The FSM and request muxing stay in the top level.

Test Plan:
- Core read: c_req=1, c_we=0, c_addr=0x40; mem_ack in the 1st BUSY cycle with mem_rdata=0xDEADBEEF. Required: mem_req high in cycle 1 only; c_done in cycle 2; c_rdata=0xDEADBEEF; c_err=0; owner=0.
- Simultaneous requests after reset: c_req and d_req both held high, ack each after 2 wait cycles. Required: grant order C, D, C, D; each done pulses 1 cycle; d_done never coincides with c_done.
- DMA write: d_we=1, d_addr=0x100, d_wdata=0x12345678, ack after 5 cycles. Required: mem_we=1, mem_addr=0x100 and mem_wdata=0x12345678 stable for all 5 BUSY cycles; d_done on the cycle after the ack.
- Timeout: core request, mem_ack never asserted, TIMEOUT=16. Required: c_done 16 cycles after the first BUSY cycle; c_err=1; c_rdata=0; then IDLE with busy=0.
- Ack on the expiry cycle: ack asserted exactly on counter = TIMEOUT-1. Required: c_err=0 and the data is captured.
- Reset mid-BUSY: assert reset for one cycle during BUSY. Required: next cycle mem_req=0, busy=0, all done=0. With both requesters active afterwards, the core is granted first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter: FSM state encoding and
// the owner codes used on the owner output and in the grant logic.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_DMA  = 1'b1;

endpackage

// File: rtl/arb_watchdog.sv
// Transaction watchdog: counts BUSY cycles without an ack and flags expiry
// once the count reaches TIMEOUT-1.
module arb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the core and the DMA
// loader; holds the granted request until ack or watchdog expiry.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_done,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  arb_state_t        state_q, state_d;
  logic              owner_q;
  logic              last_grant_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] c_rdata_q, d_rdata_q;
  logic              c_err_q, d_err_q;

  logic grant_valid;
  logic grant_sel;
  logic expire;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    grant_valid = c_req | d_req;
    if (c_req && d_req) begin
      grant_sel = ~last_grant_q;
    end else if (d_req) begin
      grant_sel = OWNER_DMA;
    end else begin
      grant_sel = OWNER_CORE;
    end
  end

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear_i  ((state_q == IDLE) && grant_valid),
    .en_i     ((state_q == BUSY) && !mem_ack && !expire),
    .expire_o (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_valid) state_d = BUSY;
      BUSY:    if (mem_ack || expire) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req = (state_q == BUSY);
    busy    = (state_q != IDLE);
    c_done  = (state_q == DONE) && (owner_q == OWNER_CORE);
    d_done  = (state_q == DONE) && (owner_q == OWNER_DMA);
  end

  // Ack is tested before expiry so a late ack on the last cycle still wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q      <= OWNER_CORE;
      last_grant_q <= OWNER_DMA;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      c_rdata_q    <= '0;
      d_rdata_q    <= '0;
      c_err_q      <= 1'b0;
      d_err_q      <= 1'b0;
    end else begin
      if (state_q == IDLE && grant_valid) begin
        owner_q      <= grant_sel;
        last_grant_q <= grant_sel;
        mem_we_q     <= grant_sel ? d_we    : c_we;
        mem_addr_q   <= grant_sel ? d_addr  : c_addr;
        mem_wdata_q  <= grant_sel ? d_wdata : c_wdata;
      end
      if (state_q == BUSY && (mem_ack || expire)) begin
        if (owner_q == OWNER_DMA) begin
          d_rdata_q <= mem_ack ? mem_rdata : '0;
          d_err_q   <= ~mem_ack;
        end else begin
          c_rdata_q <= mem_ack ? mem_rdata : '0;
          c_err_q   <= ~mem_ack;
        end
      end
    end
  end

  assign owner     = owner_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign c_rdata   = c_rdata_q;
  assign c_err     = c_err_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;

endmodule
